// File: rtl/dma_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dma_ctrl_pkg
// Description : Shared types and the round-robin pick helper for the DMA
//               channel scheduler and later multi-master arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_ctrl_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } sched_state_t;

  // Widest request vector the pick helper handles.
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_CH_W = 5;

  typedef struct packed {
    logic                found;
    logic [MAX_CH_W-1:0] idx;
  } rr_pick_t;

  // First set bit of eligible at or after ptr, wrapping n-1 -> 0.
  // ptr must be below n; ptr + offset stays below 2*n so one conditional
  // subtract replaces a modulo.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]   eligible,
                                       input logic [MAX_CH_W-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t          res;
    logic [MAX_CH_W:0] cand;
    res = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      cand = {1'b0, ptr} + (MAX_CH_W+1)'(i);
      if (cand >= (MAX_CH_W+1)'(n)) begin
        cand = cand - (MAX_CH_W+1)'(n);
      end
      if (!res.found && (i < n) && eligible[cand[MAX_CH_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_CH_W-1:0];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : dma_channel_scheduler_if
// Description : Peripheral request/ack pins plus engine start/done handshake
//               seen by the DMA channel scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_channel_scheduler_if #(
  parameter int unsigned CHANNELS_AMOUNT = 1
);
  localparam int unsigned CH_W = $clog2(CHANNELS_AMOUNT > 1 ? CHANNELS_AMOUNT : 2);

  logic [CHANNELS_AMOUNT-1:0] request_i;
  logic [CHANNELS_AMOUNT-1:0] ch_enable_i;
  logic [CHANNELS_AMOUNT-1:0] acknowledge_o;
  logic                       start_valid_o;
  logic                       start_ready_i;
  logic [CH_W-1:0]            start_channel_o;
  logic                       done_i;
  logic                       busy_o;
  logic                       timeout_o;
  logic [CH_W-1:0]            timeout_ch_o;

  // Scheduler side.
  modport master (
    input  request_i, ch_enable_i, start_ready_i, done_i,
    output acknowledge_o, start_valid_o, start_channel_o, busy_o,
           timeout_o, timeout_ch_o
  );

  // Peripheral/engine side.
  modport slave (
    output request_i, ch_enable_i, start_ready_i, done_i,
    input  acknowledge_o, start_valid_o, start_channel_o, busy_o,
           timeout_o, timeout_ch_o
  );

endinterface
`default_nettype wire

// File: rtl/dma_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_rr_arbiter
// Description : Combinational rotate-priority pick over CHANNELS_AMOUNT
//               request bits starting at a pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_rr_arbiter #(
  parameter  int unsigned CHANNELS_AMOUNT = 1,
  localparam int unsigned CH_W = $clog2(CHANNELS_AMOUNT > 1 ? CHANNELS_AMOUNT : 2)
) (
  input  wire logic [CHANNELS_AMOUNT-1:0] eligible_i,
  input  wire logic [CH_W-1:0]            ptr_i,
  output logic      [CH_W-1:0]            grant_o,
  output logic                            found_o
);
  import dma_ctrl_pkg::*;

  logic [MAX_CH-1:0]   elig_pad;
  logic [MAX_CH_W-1:0] ptr_pad;
  rr_pick_t            pick;

  assign elig_pad = MAX_CH'(eligible_i);
  assign ptr_pad  = MAX_CH_W'(ptr_i);
  assign pick     = rr_pick(elig_pad, ptr_pad, CHANNELS_AMOUNT);
  assign found_o  = pick.found;
  assign grant_o  = pick.idx[CH_W-1:0];

  // Index bits above CH_W are always zero for a legal pointer.
  wire unused_pick_hi = &{1'b0, pick};

endmodule
`default_nettype wire

// File: rtl/dma_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dma_channel_scheduler
// Description : Round-robin sharing of one DMA engine between
//               CHANNELS_AMOUNT peripheral request lines: grant, start
//               handshake, wait for done, one-cycle acknowledge.
// Options     : DMA_SCHED_TIMEOUT_EN - BUSY watchdog with timeout abort pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_channel_scheduler #(
  parameter  int unsigned CHANNELS_AMOUNT = 1,
  parameter  int unsigned TIMEOUT_W       = 16,
  localparam int unsigned CH_W = $clog2(CHANNELS_AMOUNT > 1 ? CHANNELS_AMOUNT : 2)
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  dma_channel_scheduler_if.master bus
);
  import dma_ctrl_pkg::*;

  if (CHANNELS_AMOUNT < 1 || CHANNELS_AMOUNT > MAX_CH || TIMEOUT_W < 1) begin : g_bad_params
    $error("dma_channel_scheduler: illegal CHANNELS_AMOUNT or TIMEOUT_W");
  end

  sched_state_t               state_q;
  logic [CH_W-1:0]            rr_ptr_q;
  logic [CH_W-1:0]            cur_q;
  logic [CHANNELS_AMOUNT-1:0] ack_q;
  logic                       start_valid_q;
  logic [CH_W-1:0]            start_ch_q;
  logic                       busy_q;

  logic [CHANNELS_AMOUNT-1:0] eligible_d;
  logic [CH_W-1:0]            pick_idx_d;
  logic                       pick_found_d;
  logic [CH_W-1:0]            ptr_next_d;
  logic                       expire_d;

  assign eligible_d = bus.request_i & bus.ch_enable_i;
  assign ptr_next_d = (cur_q == CH_W'(CHANNELS_AMOUNT - 1)) ? '0 : cur_q + 1'b1;

  dma_rr_arbiter #(
    .CHANNELS_AMOUNT (CHANNELS_AMOUNT)
  ) u_arb (
    .eligible_i (eligible_d),
    .ptr_i      (rr_ptr_q),
    .grant_o    (pick_idx_d),
    .found_o    (pick_found_d)
  );

  // Scheduler FSM: arbitrate, hold start until accepted, wait done, ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cur_q         <= '0;
      ack_q         <= '0;
      start_valid_q <= 1'b0;
      start_ch_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found_d) begin
            cur_q         <= pick_idx_d;
            start_ch_q    <= pick_idx_d;
            start_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          // The grant completes even if the request drops meanwhile.
          if (bus.start_ready_i) begin
            start_valid_q <= 1'b0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (bus.done_i || expire_d) begin
            ack_q    <= CHANNELS_AMOUNT'(1) << cur_q;
            rr_ptr_q <= ptr_next_d;
            state_q  <= ACK;
          end
        end
        ACK: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q;
  logic [TIMEOUT_W-1:0] wdog_inc_d;
  logic                 timeout_q;
  logic [CH_W-1:0]      timeout_ch_q;

  assign wdog_inc_d = wdog_q + 1'b1;
  // done_i in the expiry cycle takes precedence over the timeout.
  assign expire_d   = (state_q == BUSY) && !bus.done_i && (&wdog_inc_d);

  // Watchdog counts BUSY clocks; zero everywhere else so entry starts at 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
      timeout_ch_q <= '0;
    end else begin
      wdog_q    <= (state_q == BUSY) ? wdog_inc_d : '0;
      timeout_q <= expire_d;
      if (expire_d) begin
        timeout_ch_q <= cur_q;
      end
    end
  end

  assign bus.timeout_o    = timeout_q;
  assign bus.timeout_ch_o = timeout_ch_q;
`else
  assign expire_d         = 1'b0;
  assign bus.timeout_o    = 1'b0;
  assign bus.timeout_ch_o = '0;
`endif

  assign bus.acknowledge_o   = ack_q;
  assign bus.start_valid_o   = start_valid_q;
  assign bus.start_channel_o = start_ch_q;
  assign bus.busy_o          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_channel_scheduler
// Description : Self-checking bench for dma_channel_scheduler (4 channels).
//               Expected grants come from a transaction-level round-robin
//               model; timeout scenarios run when DMA_SCHED_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_channel_scheduler;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dma_channel_scheduler_if #(.CHANNELS_AMOUNT(N)) bus();

  dma_channel_scheduler #(
    .CHANNELS_AMOUNT (N),
    .TIMEOUT_W       (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int model_ptr = 0;

  // Count one comparison and report a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first channel at or after ptr that both requests and is enabled.
  function automatic int model_pick(input logic [N-1:0] req, input logic [N-1:0] en, input int ptr);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (req[c] && en[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_no_timeout(input string tag);
`ifndef DMA_SCHED_TIMEOUT_EN
    check_eq({tag, "_tmo"}, {31'd0, bus.timeout_o}, 32'd0);
    check_eq({tag, "_tmo_ch"}, {30'd0, bus.timeout_ch_o}, 32'd0);
`else
    check_eq({tag, "_tmo"}, {31'd0, bus.timeout_o}, 32'd0);
`endif
  endtask

  // One complete scheduling round starting with the DUT in IDLE.
  task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] en,
                         input int ready_wait, input int done_wait,
                         input bit drop_req, output int granted);
    int exp_ch;
    bus.request_i   = req;
    bus.ch_enable_i = en;
    exp_ch  = model_pick(req, en, model_ptr);
    granted = -1;
    if (exp_ch < 0) bus.done_i = 1'b1;   // stray done while idle must be ignored
    tick();
    bus.done_i = 1'b0;
    if (exp_ch < 0) begin
      check_eq("idle_no_start", {31'd0, bus.start_valid_o}, 32'd0);
      check_eq("idle_no_busy",  {31'd0, bus.busy_o}, 32'd0);
      check_eq("idle_no_ack",   {28'd0, bus.acknowledge_o}, 32'd0);
      return;
    end
    check_eq("start_valid", {31'd0, bus.start_valid_o}, 32'd1);
    check_eq("start_ch",    {30'd0, bus.start_channel_o}, exp_ch);
    check_eq("busy_grant",  {31'd0, bus.busy_o}, 32'd1);
    for (int w = 0; w < ready_wait; w++) begin
      if (drop_req) begin
        bus.request_i   = '0;
        bus.ch_enable_i = '0;
      end
      bus.done_i = 1'b1;                 // done outside BUSY is ignored
      tick();
      check_eq("grant_hold_valid", {31'd0, bus.start_valid_o}, 32'd1);
      check_eq("grant_hold_ch",    {30'd0, bus.start_channel_o}, exp_ch);
    end
    bus.done_i        = 1'b0;
    bus.start_ready_i = 1'b1;
    tick();
    bus.start_ready_i = 1'b0;
    check_eq("hs_valid_low", {31'd0, bus.start_valid_o}, 32'd0);
    check_eq("hs_busy",      {31'd0, bus.busy_o}, 32'd1);
    for (int d = 0; d < done_wait; d++) begin
      tick();
      check_eq("busy_wait_ack", {28'd0, bus.acknowledge_o}, 32'd0);
      check_eq("busy_wait",     {31'd0, bus.busy_o}, 32'd1);
    end
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    check_eq("ack_onehot", {28'd0, bus.acknowledge_o}, 32'd1 << exp_ch);
    check_eq("ack_busy",   {31'd0, bus.busy_o}, 32'd1);
    check_no_timeout("ack");
    model_ptr = (exp_ch + 1) % N;
    granted   = exp_ch;
    tick();
    check_eq("post_ack",      {28'd0, bus.acknowledge_o}, 32'd0);
    check_eq("post_ack_busy", {31'd0, bus.busy_o}, 32'd0);
    check_eq("post_ack_sv",   {31'd0, bus.start_valid_o}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ack"},  {28'd0, bus.acknowledge_o}, 32'd0);
    check_eq({tag, "_sv"},   {31'd0, bus.start_valid_o}, 32'd0);
    check_eq({tag, "_ch"},   {30'd0, bus.start_channel_o}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
    check_eq({tag, "_tmo"},  {31'd0, bus.timeout_o}, 32'd0);
    check_eq({tag, "_tch"},  {30'd0, bus.timeout_ch_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    int order [5] = '{0, 1, 2, 3, 0};
    bus.request_i     = '0;
    bus.ch_enable_i   = '0;
    bus.start_ready_i = 1'b0;
    bus.done_i        = 1'b0;
    rst_n             = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // All channels requesting: strict rotation.
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 4'b1111, i % 2, 1 + i, 1'b0, g);
      check_eq("rr_order", g, order[i]);
    end

    // Single request, engine ready at once, done 5 clocks after start.
    run_txn(4'b0001, 4'b1111, 0, 4, 1'b0, g);
    check_eq("single_ch0", g, 0);

    // Disabled channel never wins until enabled.
    run_txn(4'b0100, 4'b1011, 0, 0, 1'b0, g);
    check_eq("disabled_none", g, -1);
    run_txn(4'b0100, 4'b1011, 0, 0, 1'b0, g);
    check_eq("disabled_none2", g, -1);
    run_txn(4'b0100, 4'b1111, 0, 1, 1'b0, g);
    check_eq("enabled_ch2", g, 2);

    // Long ready stall with request dropped mid-wait.
    run_txn(4'b0010, 4'b1111, 10, 2, 1'b1, g);
    check_eq("stall_drop_ch1", g, 1);

    // Reset while BUSY: outputs clear without a clock; pointer returns to 0.
    bus.request_i   = 4'b0100;
    bus.ch_enable_i = 4'b1111;
    tick();
    check_eq("pre_rst_ch", {30'd0, bus.start_channel_o}, 32'd2);
    bus.start_ready_i = 1'b1;
    tick();
    bus.start_ready_i = 1'b0;
    tick();
    check_eq("pre_rst_busy", {31'd0, bus.busy_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.request_i = '0;
    tick();
    rst_n     = 1'b1;
    model_ptr = 0;
    run_txn(4'b1111, 4'b1111, 0, 0, 1'b0, g);
    check_eq("rst_ptr_ch0", g, 0);

    // Randomized rounds against the model.
    for (int i = 0; i < 60; i++) begin
      run_txn(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 1'($urandom), g);
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    // No done: timeout 15 clocks after handshake, channel still acked.
    bus.request_i   = 4'b1000;
    bus.ch_enable_i = 4'b1111;
    tick();
    check_eq("tmo_start_ch", {30'd0, bus.start_channel_o}, 32'd3);
    bus.start_ready_i = 1'b1;
    tick();
    bus.start_ready_i = 1'b0;
    for (int k = 1; k < 15; k++) begin
      tick();
      check_eq("tmo_early", {31'd0, bus.timeout_o}, 32'd0);
    end
    tick();
    check_eq("tmo_pulse", {31'd0, bus.timeout_o}, 32'd1);
    check_eq("tmo_ch",    {30'd0, bus.timeout_ch_o}, 32'd3);
    check_eq("tmo_ack",   {28'd0, bus.acknowledge_o}, 32'b1000);
    model_ptr = 0;
    tick();
    check_eq("tmo_one_cycle", {31'd0, bus.timeout_o}, 32'd0);
    check_eq("tmo_ch_held",   {30'd0, bus.timeout_ch_o}, 32'd3);

    // done on the expiry cycle wins.
    bus.request_i = 4'b0010;
    tick();
    bus.start_ready_i = 1'b1;
    tick();
    bus.start_ready_i = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    check_eq("tmo_done_wins", {31'd0, bus.timeout_o}, 32'd0);
    check_eq("tmo_done_ack",  {28'd0, bus.acknowledge_o}, 32'b0010);
    check_eq("tmo_ch_kept",   {30'd0, bus.timeout_ch_o}, 32'd3);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
